// File: rtl/alu_definitions_pkg.sv
// rtl/alu_definitions_pkg.sv - shared ALU control encodings, arbiter states and datapath width
package alu_definitions;

  localparam int ALU_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit integer ALU
module alu
  import alu_definitions::*;
(
  input  logic [ALU_W-1:0] op1,
  input  logic [ALU_W-1:0] op2,
  input  alu_ctrl_t        ctrl,
  output logic [ALU_W-1:0] result
);

  logic [4:0] shamt;

  assign shamt = op2[4:0];

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_ADD:  result = op1 + op2;
      ALU_SUB:  result = op1 - op2;
      ALU_SLL:  result = op1 << shamt;
      ALU_SLT:  result = {{(ALU_W-1){1'b0}}, $signed(op1) < $signed(op2)};
      ALU_SLTU: result = {{(ALU_W-1){1'b0}}, op1 < op2};
      ALU_XOR:  result = op1 ^ op2;
      ALU_SRL:  result = op1 >> shamt;
      ALU_SRA:  result = $unsigned($signed(op1) >>> shamt);
      ALU_OR:   result = op1 | op2;
      ALU_AND:  result = op1 & op2;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, one-hot grant searched from ptr upward
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between N_REQ requesters with round-robin grant
module alu_arbiter
  import alu_definitions::*;
#(
  parameter int N_REQ = 2,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*ALU_W-1:0] req_op1,
  input  logic [N_REQ*ALU_W-1:0] req_op2,
  input  logic [N_REQ*4-1:0]     req_ctrl,
  input  logic [N_REQ*TAG_W-1:0] req_tag,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [ALU_W-1:0]       rsp_result,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   busy
);

  localparam int PTR_W = $clog2(N_REQ);

  arb_state_t       state, next_state;
  logic [PTR_W-1:0] rr_ptr, owner, grant_idx, next_ptr;
  logic [N_REQ-1:0] grant;
  logic             accept;
  logic [ALU_W-1:0] op1_q, op2_q, result_q, alu_result, sel_op1, sel_op2;
  alu_ctrl_t        ctrl_q, sel_ctrl;
  logic [TAG_W-1:0] tag_q, sel_tag;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  alu u_alu (
    .op1    (op1_q),
    .op2    (op2_q),
    .ctrl   (ctrl_q),
    .result (alu_result)
  );

  always_comb begin
    grant_idx = '0;
    sel_op1   = '0;
    sel_op2   = '0;
    sel_ctrl  = ALU_ADD;
    sel_tag   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = PTR_W'(i);
        sel_op1   = req_op1[ALU_W*i +: ALU_W];
        sel_op2   = req_op2[ALU_W*i +: ALU_W];
        sel_ctrl  = alu_ctrl_t'(req_ctrl[4*i +: 4]);
        sel_tag   = req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  assign next_ptr = (grant_idx == PTR_W'(N_REQ-1)) ? '0 : grant_idx + PTR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // req_ready is gated by rst so no grant is advertised while reset is held
  always_comb begin
    next_state = state;
    req_ready  = '0;
    rsp_valid  = '0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          req_ready = grant;
          accept    = |(req_valid & grant);
        end
        if (accept) next_state = EXEC;
      end
      EXEC: next_state = RESP;
      RESP: begin
        for (int i = 0; i < N_REQ; i++) rsp_valid[i] = (owner == PTR_W'(i));
        if (rsp_ready[owner]) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      owner    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      ctrl_q   <= ALU_ADD;
      tag_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op1_q  <= sel_op1;
        op2_q  <= sel_op2;
        ctrl_q <= sel_ctrl;
        tag_q  <= sel_tag;
        owner  <= grant_idx;
        rr_ptr <= next_ptr;
      end
      if (state == EXEC) result_q <= alu_result;
    end
  end

  assign busy       = (state != IDLE);
  assign rsp_result = result_q;
  assign rsp_tag    = tag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter against a transaction-level model
module tb_alu_arbiter;
  import alu_definitions::*;

  localparam int N = 2;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_op1 = '0;
  logic [N*32-1:0] req_op2 = '0;
  logic [N*4-1:0]  req_ctrl = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic [31:0]     rsp_result;
  logic [TW-1:0]   rsp_tag;
  logic            busy;

  int checks = 0;
  int errors = 0;

  logic        pv[N];
  logic [31:0] pa[N];
  logic [31:0] pb[N];
  logic [3:0]  pc[N];
  logic [3:0]  pt[N];

  alu_arbiter #(.N_REQ(N), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_ctrl   (req_ctrl),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference arithmetic expressed with plain integer operations
  function automatic logic [31:0] model_alu(input int c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = b % 32;
    case (c)
      0: return a + b;
      1: return a - b;
      2: return a * (32'd1 << s);
      3: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4: return (a < b) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a / (32'd1 << s);
      7: return (a / (32'd1 << s)) | (a[31] ? ~(32'hFFFF_FFFF / (32'd1 << s)) : 32'd0);
      8: return a | b;
      9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = pv[i];
      req_op1[32*i +: 32]   = pa[i];
      req_op2[32*i +: 32]   = pb[i];
      req_ctrl[4*i +: 4]    = pc[i];
      req_tag[TW*i +: TW]   = pt[i];
    end
  endtask

  task automatic set_req(input int p, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] t);
    pv[p] = 1'b1; pc[p] = c; pa[p] = a; pb[p] = b; pt[p] = t;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0; pa[i] = '0; pb[i] = '0; pc[i] = '0; pt[i] = '0;
    end
    drive();
  endtask

  // Runs from the cycle after accept through the response handshake
  task automatic finish_op(input int p, input logic [31:0] exp, input logic [3:0] etag,
                           input int delay, input string name);
    settle();
    checks++;
    if (busy !== 1'b1 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL %s_exec: busy=%b rsp_valid=%b, required busy=1 rsp_valid=00", name, busy, rsp_valid);
    end
    step(); settle();
    for (int d = 0; d < delay; d++) begin
      checks++;
      if (rsp_valid !== 2'(1 << p) || rsp_result !== exp || rsp_tag !== etag) begin
        errors++;
        $display("FAIL %s_hold: rsp_valid=%b result=%h tag=%h, required %b %h %h",
                 name, rsp_valid, rsp_result, rsp_tag, 2'(1 << p), exp, etag);
      end
      step(); settle();
    end
    rsp_ready[p] = 1'b1;
    checks++;
    if (rsp_valid !== 2'(1 << p) || rsp_result !== exp || rsp_tag !== etag) begin
      errors++;
      $display("FAIL %s_rsp: rsp_valid=%b result=%h tag=%h, required %b %h %h",
               name, rsp_valid, rsp_result, rsp_tag, 2'(1 << p), exp, etag);
    end
    step();
    rsp_ready = '0;
    settle();
    checks++;
    if (busy !== 1'b0 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL %s_done: busy=%b rsp_valid=%b, required busy=0 rsp_valid=00", name, busy, rsp_valid);
    end
  endtask

  task automatic run_op(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, input logic [31:0] exp, input int delay, input string name);
    step();
    clear_reqs();
    set_req(p, c, a, b, t);
    drive();
    settle();
    checks++;
    if (req_ready !== 2'(1 << p)) begin
      errors++;
      $display("FAIL %s_grant: req_ready=%b, required %b", name, req_ready, 2'(1 << p));
    end
    step();
    pv[p] = 1'b0;
    drive();
    finish_op(p, exp, t, delay, name);
  endtask

  task automatic test_reset();
    set_req(0, 4'(ALU_ADD), 32'd1, 32'd2, 4'd1);
    set_req(1, 4'(ALU_ADD), 32'd3, 32'd4, 4'd2);
    drive();
    rst = 1'b1;
    step(); step();
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || busy !== 1'b0 || rsp_result !== '0 || rsp_tag !== '0) begin
      errors++;
      $display("FAIL reset_state: req_ready=%b rsp_valid=%b busy=%b result=%h tag=%h, required all zero",
               req_ready, rsp_valid, busy, rsp_result, rsp_tag);
    end
    clear_reqs();
  endtask

  task automatic test_single();
    run_op(0, 4'(ALU_ADD), 32'd5, 32'd7, 4'd3, 32'd12, 0, "single");
  endtask

  task automatic test_contention();
    int ptr;
    int g;
    logic [31:0] exp;
    clear_reqs();
    rsp_ready = '1;
    set_req(0, 4'(ALU_SUB), 32'd10, 32'd3, 4'd5);
    set_req(1, 4'(ALU_SLTU), 32'd1, 32'hFFFF_FFFF, 4'd9);
    drive();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    settle();
    ptr = 0;
    for (int op = 0; op < 8; op++) begin
      g = ptr;
      exp = model_alu(int'(pc[g]), pa[g], pb[g]);
      checks++;
      if (req_ready !== 2'(1 << g) || g != (op % 2)) begin
        errors++;
        $display("FAIL contention_grant%0d: req_ready=%b, required %b", op, req_ready, 2'(1 << g));
      end
      step(); settle();
      step(); settle();
      checks++;
      if (rsp_valid !== 2'(1 << g) || rsp_result !== exp || rsp_tag !== pt[g]) begin
        errors++;
        $display("FAIL contention_rsp%0d: rsp_valid=%b result=%h tag=%h, required %b %h %h",
                 op, rsp_valid, rsp_result, rsp_tag, 2'(1 << g), exp, pt[g]);
      end
      ptr = (g + 1) % N;
      step(); settle();
    end
    clear_reqs();
    rsp_ready = '0;
  endtask

  task automatic test_backpressure();
    step();
    clear_reqs();
    set_req(1, 4'(ALU_SRA), 32'h8000_0000, 32'd4, 4'd6);
    drive();
    settle();
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_grant: req_ready=%b, required 10", req_ready);
    end
    step();
    pv[1] = 1'b0;
    set_req(0, 4'(ALU_ADD), 32'd2, 32'd3, 4'd1);
    drive();
    step(); settle();
    for (int d = 0; d < 5; d++) begin
      checks++;
      if (rsp_valid !== 2'b10 || rsp_result !== 32'hF800_0000 || req_ready !== 2'b00 || rsp_tag !== 4'd6) begin
        errors++;
        $display("FAIL bp_hold%0d: rsp_valid=%b result=%h req_ready=%b tag=%h, required 10 f8000000 00 6",
                 d, rsp_valid, rsp_result, req_ready, rsp_tag);
      end
      step(); settle();
    end
    rsp_ready = 2'b10;
    step();
    rsp_ready = '0;
    settle();
    checks++;
    if (req_ready !== 2'b01 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: req_ready=%b busy=%b, required 01 0", req_ready, busy);
    end
    step();
    pv[0] = 1'b0;
    drive();
    finish_op(0, 32'd5, 4'd1, 0, "bp_next");
  endtask

  task automatic test_boundaries();
    run_op(0, 4'(ALU_SLL), 32'd1, 32'h21, 4'd2, 32'd2, 1, "sll_shamt");
    run_op(1, 4'(ALU_ADD), 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd0, 0, "add_wrap");
    run_op(0, 4'(ALU_SLT), 32'hFFFF_FFFF, 32'd1, 4'd7, 32'd1, 0, "slt_signed");
    run_op(1, 4'hC, 32'h1234_5678, 32'h9ABC_DEF0, 4'd8, 32'd0, 0, "undef_ctrl");
  endtask

  task automatic test_reset_mid_op();
    step();
    clear_reqs();
    set_req(0, 4'(ALU_ADD), 32'd1, 32'd1, 4'd2);
    drive();
    step();
    pv[0] = 1'b0;
    drive();
    settle();
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL rst_async: busy=%b rsp_valid=%b, required 0 00", busy, rsp_valid);
    end
    step(); step();
    rst = 1'b0;
    set_req(0, 4'(ALU_ADD), 32'd1, 32'd1, 4'd2);
    set_req(1, 4'(ALU_OR), 32'hF0, 32'h0F, 4'd11);
    drive();
    settle();
    checks++;
    if (req_ready !== 2'b01 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL rst_ptr: req_ready=%b rsp_valid=%b, required 01 00", req_ready, rsp_valid);
    end
    pv[0] = 1'b0;
    drive();
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL rst_port1: req_ready=%b, required 10", req_ready);
    end
    step();
    pv[1] = 1'b0;
    drive();
    finish_op(1, 32'hFF, 4'd11, 0, "rst_next");
  endtask

  task automatic test_wrong_port_ready();
    step();
    clear_reqs();
    set_req(0, 4'(ALU_XOR), 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd13);
    drive();
    step();
    pv[0] = 1'b0;
    drive();
    step(); settle();
    rsp_ready = 2'b10;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (rsp_valid !== 2'b01 || busy !== 1'b1 || rsp_result !== 32'hF00F_F00F) begin
        errors++;
        $display("FAIL wrong_ready%0d: rsp_valid=%b busy=%b result=%h, required 01 1 f00ff00f",
                 d, rsp_valid, busy, rsp_result);
      end
      step(); settle();
    end
    rsp_ready = 2'b01;
    step();
    rsp_ready = '0;
    settle();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wrong_ready_done: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_random();
    int ptr;
    int g;
    int delay;
    logic [31:0] exp;
    logic [3:0]  etag;
    step();
    clear_reqs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    ptr = 0;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++)
        if (!pv[i] && ($urandom_range(1, 0) == 1))
          set_req(i, 4'($urandom_range(15, 0)), $urandom, ($urandom_range(1, 0) == 1) ? $urandom : 32'($urandom_range(40, 0)), 4'($urandom));
      if (!pv[0] && !pv[1]) begin
        g = $urandom_range(N-1, 0);
        set_req(g, 4'($urandom_range(15, 0)), $urandom, $urandom, 4'($urandom));
      end
      drive();
      settle();
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && pv[(ptr + k) % N]) g = (ptr + k) % N;
      exp  = model_alu(int'(pc[g]), pa[g], pb[g]);
      etag = pt[g];
      checks++;
      if (req_ready !== 2'(1 << g)) begin
        errors++;
        $display("FAIL rand%0d_grant: req_ready=%b, required %b", n, req_ready, 2'(1 << g));
      end
      step();
      pv[g] = 1'b0;
      ptr = (g + 1) % N;
      drive();
      settle();
      checks++;
      if (rsp_valid !== '0 || req_ready !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d_exec: rsp_valid=%b req_ready=%b busy=%b, required 00 00 1", n, rsp_valid, req_ready, busy);
      end
      step(); settle();
      delay = $urandom_range(3, 0);
      for (int d = 0; d <= delay; d++) begin
        if (d == delay) rsp_ready = 2'($urandom) | 2'(1 << g);
        else            rsp_ready = 2'($urandom) & ~2'(1 << g);
        checks++;
        if (rsp_valid !== 2'(1 << g) || rsp_result !== exp || rsp_tag !== etag || req_ready !== '0) begin
          errors++;
          $display("FAIL rand%0d_rsp: rsp_valid=%b result=%h tag=%h req_ready=%b, required %b %h %h 00",
                   n, rsp_valid, rsp_result, rsp_tag, req_ready, 2'(1 << g), exp, etag);
        end
        step();
        rsp_ready = '0;
        settle();
      end
    end
    clear_reqs();
  endtask

  initial begin
    clear_reqs();
    test_reset();
    rst = 1'b0;
    test_single();
    test_contention();
    test_backpressure();
    test_boundaries();
    test_reset_mid_op();
    test_wrong_port_ready();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
